// File: rtl/xadc_channel_monitor.sv
// xadc_channel_monitor
// Sits between the XADC wizard (channel-sequencer mode) and user logic.
// Each end-of-conversion on a channel listed in CH_ADDRS triggers one guarded
// DRP read. Per channel it keeps the last code, a block average, min/max and
// a hysteresis high-alarm. Dropped conversions and DRP timeouts are counted.

module xadc_channel_monitor #(
    parameter int unsigned        N_CH     = 4,
    parameter logic [7*N_CH-1:0]  CH_ADDRS = {7'h06, 7'h02, 7'h01, 7'h00},
    parameter int unsigned        AVG_LOG2 = 2,
    parameter logic [11:0]        HYST     = 12'd16,
    parameter int unsigned        TIMEOUT  = 15,
    localparam int unsigned       SEL_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 eoc_in,
    input  logic [4:0]           channel_in,
    output logic                 den_out,
    output logic                 dwe_out,
    output logic [15:0]          di_out,
    output logic [6:0]           daddr_out,
    input  logic                 drdy_in,
    input  logic [15:0]          do_in,
    input  logic [12*N_CH-1:0]   thr_hi_in,
    input  logic                 clr_minmax_in,
    input  logic [SEL_W-1:0]     sel_in,
    output logic [11:0]          sel_last_out,
    output logic [11:0]          sel_avg_out,
    output logic [11:0]          sel_min_out,
    output logic [11:0]          sel_max_out,
    output logic                 upd_valid_out,
    output logic [SEL_W-1:0]     upd_idx_out,
    output logic [11:0]          upd_data_out,
    output logic [N_CH-1:0]      alarm_out,
    output logic [7:0]           overrun_cnt_out,
    output logic [7:0]           timeout_cnt_out
);

    localparam int unsigned ACC_W = 12 + AVG_LOG2;
    localparam int unsigned CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((1 << AVG_LOG2) - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_STORE
    } state_t;

    // Read sequencer state
    state_t             r_state;
    logic [SEL_W-1:0]   r_idx;
    logic [6:0]         r_daddr;
    logic               r_den;
    logic [TMR_W-1:0]   r_timer;
    logic [11:0]        r_code;
    logic               r_upd_valid;
    logic [7:0]         r_ovr_cnt;
    logic [7:0]         r_tmo_cnt;

    // Per-channel storage
    logic [11:0]        r_last [N_CH];
    logic [11:0]        r_avg  [N_CH];
    logic [11:0]        r_min  [N_CH];
    logic [11:0]        r_max  [N_CH];
    logic [ACC_W-1:0]   r_acc  [N_CH];
    logic [CNT_W-1:0]   r_cnt  [N_CH];
    logic [N_CH-1:0]    r_alarm;

    // Combinational helpers
    logic               w_hit;
    logic [SEL_W-1:0]   w_hit_idx;
    logic [11:0]        w_thr;
    logic [11:0]        w_min_base;
    logic [11:0]        w_max_base;
    logic [11:0]        w_min_new;
    logic [11:0]        w_max_new;
    logic [ACC_W-1:0]   w_sum;
    logic               w_wrap;
    logic [11:0]        w_avg_new;
    logic               w_alarm_new;
    logic               w_sel_ok;

    // Channel table lookup: lowest matching index wins
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (!w_hit && ({2'b00, channel_in} == CH_ADDRS[7*i +: 7])) begin
                w_hit     = 1'b1;
                w_hit_idx = SEL_W'(i);
            end
        end
    end

    // Sequencer: IDLE -> REQ (den pulse) -> WAIT (drdy or timeout) -> STORE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_daddr     <= '0;
            r_den       <= 1'b0;
            r_timer     <= '0;
            r_code      <= '0;
            r_upd_valid <= 1'b0;
            r_ovr_cnt   <= '0;
            r_tmo_cnt   <= '0;
        end else begin
            r_den       <= 1'b0;
            r_upd_valid <= 1'b0;
            if (eoc_in && w_hit && (r_state != ST_IDLE) && (r_ovr_cnt != 8'hFF)) begin
                r_ovr_cnt <= r_ovr_cnt + 8'd1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (eoc_in && w_hit) begin
                        r_idx   <= w_hit_idx;
                        r_daddr <= {2'b00, channel_in};
                        r_den   <= 1'b1;
                        r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    r_timer <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (drdy_in) begin
                        r_code      <= do_in[15:4];
                        r_upd_valid <= 1'b1;
                        r_state     <= ST_STORE;
                    end else if (r_timer == TMR_W'(TIMEOUT)) begin
                        if (r_tmo_cnt != 8'hFF) begin
                            r_tmo_cnt <= r_tmo_cnt + 8'd1;
                        end
                        r_state <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                ST_STORE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Next-value computation for the channel being stored
    always_comb begin
        w_thr = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (r_idx == SEL_W'(i)) begin
                w_thr = thr_hi_in[12*i +: 12];
            end
        end
        // A coincident clear must be seen before the new sample is folded in
        w_min_base = clr_minmax_in ? 12'hFFF : r_min[r_idx];
        w_max_base = clr_minmax_in ? 12'h000 : r_max[r_idx];
        w_min_new  = (r_code < w_min_base) ? r_code : w_min_base;
        w_max_new  = (r_code > w_max_base) ? r_code : w_max_base;
        w_sum      = r_acc[r_idx] + ACC_W'(r_code);
        w_wrap     = (r_cnt[r_idx] == CNT_MAX);
        w_avg_new  = 12'(w_sum >> AVG_LOG2);
        if (w_avg_new > w_thr) begin
            w_alarm_new = 1'b1;
        end else if (({1'b0, w_avg_new} + {1'b0, HYST}) <= {1'b0, w_thr}) begin
            w_alarm_new = 1'b0;
        end else begin
            w_alarm_new = r_alarm[r_idx];
        end
    end

    // Per-channel trackers: clear of min/max, then store of the captured sample
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                r_last[i] <= '0;
                r_avg[i]  <= '0;
                r_min[i]  <= '1;
                r_max[i]  <= '0;
                r_acc[i]  <= '0;
                r_cnt[i]  <= '0;
            end
            r_alarm <= '0;
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (clr_minmax_in) begin
                    r_min[i] <= '1;
                    r_max[i] <= '0;
                end
                if ((r_state == ST_STORE) && (r_idx == SEL_W'(i))) begin
                    r_last[i] <= r_code;
                    r_min[i]  <= w_min_new;
                    r_max[i]  <= w_max_new;
                    if (w_wrap) begin
                        r_acc[i]   <= '0;
                        r_cnt[i]   <= '0;
                        r_avg[i]   <= w_avg_new;
                        r_alarm[i] <= w_alarm_new;
                    end else begin
                        r_acc[i] <= w_sum;
                        r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Readback mux; out-of-range selects read as zero
    always_comb begin
        w_sel_ok     = (32'(sel_in) < N_CH);
        sel_last_out = '0;
        sel_avg_out  = '0;
        sel_min_out  = '0;
        sel_max_out  = '0;
        if (w_sel_ok) begin
            sel_last_out = r_last[sel_in];
            sel_avg_out  = r_avg[sel_in];
            sel_min_out  = r_min[sel_in];
            sel_max_out  = r_max[sel_in];
        end
    end

    assign den_out         = r_den;
    assign dwe_out         = 1'b0;
    assign di_out          = '0;
    assign daddr_out       = r_daddr;
    assign upd_valid_out   = r_upd_valid;
    assign upd_idx_out     = r_idx;
    assign upd_data_out    = r_code;
    assign alarm_out       = r_alarm;
    assign overrun_cnt_out = r_ovr_cnt;
    assign timeout_cnt_out = r_tmo_cnt;

endmodule

// File: tb/tb_xadc_channel_monitor.sv
// Directed bench for xadc_channel_monitor with default parameters.
// A transaction-level model tracks per-channel statistics; a compare
// process checks every DUT output against it on each falling edge.

module tb_xadc_channel_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        eoc_in;
    logic [4:0]  channel_in;
    logic        den_out;
    logic        dwe_out;
    logic [15:0] di_out;
    logic [6:0]  daddr_out;
    logic        drdy_in;
    logic [15:0] do_in;
    logic [47:0] thr_hi_in;
    logic        clr_minmax_in;
    logic [1:0]  sel_in;
    logic [11:0] sel_last_out;
    logic [11:0] sel_avg_out;
    logic [11:0] sel_min_out;
    logic [11:0] sel_max_out;
    logic        upd_valid_out;
    logic [1:0]  upd_idx_out;
    logic [11:0] upd_data_out;
    logic [3:0]  alarm_out;
    logic [7:0]  overrun_cnt_out;
    logic [7:0]  timeout_cnt_out;

    xadc_channel_monitor dut (
        .clk             (clk),
        .rst             (rst),
        .eoc_in          (eoc_in),
        .channel_in      (channel_in),
        .den_out         (den_out),
        .dwe_out         (dwe_out),
        .di_out          (di_out),
        .daddr_out       (daddr_out),
        .drdy_in         (drdy_in),
        .do_in           (do_in),
        .thr_hi_in       (thr_hi_in),
        .clr_minmax_in   (clr_minmax_in),
        .sel_in          (sel_in),
        .sel_last_out    (sel_last_out),
        .sel_avg_out     (sel_avg_out),
        .sel_min_out     (sel_min_out),
        .sel_max_out     (sel_max_out),
        .upd_valid_out   (upd_valid_out),
        .upd_idx_out     (upd_idx_out),
        .upd_data_out    (upd_data_out),
        .alarm_out       (alarm_out),
        .overrun_cnt_out (overrun_cnt_out),
        .timeout_cnt_out (timeout_cnt_out)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int          m_last [4];
    int          m_avg  [4];
    int          m_min  [4];
    int          m_max  [4];
    int          m_blk  [4][$];
    logic [3:0]  m_alarm;
    int          m_ovr;
    int          m_tmo;
    int          m_thr  [4] = '{4095, 1000, 4095, 4095};
    int          m_addr [4] = '{0, 1, 2, 6};
    bit          exp_den;
    int          exp_addr;
    bit          exp_upd;
    int          exp_idx;
    int          exp_data;
    bit          chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lookup(input int ch);
        for (int i = 0; i < 4; i++) begin
            if (m_addr[i] == ch) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_last[i] = 0;
            m_avg[i]  = 0;
            m_min[i]  = 12'hFFF;
            m_max[i]  = 0;
            m_blk[i].delete();
        end
        m_alarm  = '0;
        m_ovr    = 0;
        m_tmo    = 0;
        exp_den  = 1'b0;
        exp_upd  = 1'b0;
        exp_addr = 0;
        exp_idx  = 0;
        exp_data = 0;
    endtask

    // A sample lands: optional global clear first, then stats of its channel
    task automatic model_store(input int ch, input int code, input bit clr);
        int sum;
        if (clr) begin
            for (int i = 0; i < 4; i++) begin
                m_min[i] = 12'hFFF;
                m_max[i] = 0;
            end
        end
        m_last[ch] = code;
        if (code < m_min[ch]) m_min[ch] = code;
        if (code > m_max[ch]) m_max[ch] = code;
        m_blk[ch].push_back(code);
        if (m_blk[ch].size() == 4) begin
            sum = 0;
            foreach (m_blk[ch][k]) sum += m_blk[ch][k];
            m_avg[ch] = sum / 4;
            if (m_avg[ch] > m_thr[ch]) m_alarm[ch] = 1'b1;
            else if (m_avg[ch] + 16 <= m_thr[ch]) m_alarm[ch] = 1'b0;
            m_blk[ch].delete();
        end
    endtask

    // One clock: return just after the rising edge, rotate readback select
    task automatic tick();
        @(posedge clk);
        #1;
        sel_in = sel_in + 2'd1;
    endtask

    // Full read: eoc, den, wait_cycles in WAIT, drdy with data, store
    task automatic do_read(input logic [4:0] ch, input int wait_cycles,
                           input logic [15:0] d, input bit clr_at_store);
        int idx;
        idx = lookup(int'(ch));
        eoc_in = 1'b1; channel_in = ch;
        tick();
        eoc_in = 1'b0;
        exp_den = 1'b1; exp_addr = int'(ch);
        tick();
        exp_den = 1'b0;
        repeat (wait_cycles) tick();
        drdy_in = 1'b1; do_in = d;
        tick();
        drdy_in = 1'b0; do_in = '0;
        exp_upd = 1'b1; exp_idx = idx; exp_data = int'(d[15:4]);
        clr_minmax_in = clr_at_store;
        tick();
        clr_minmax_in = 1'b0;
        exp_upd = 1'b0;
        model_store(idx, int'(d[15:4]), clr_at_store);
    endtask

    task automatic lit(input string name, input logic [1:0] s, input int which, input int exp);
        logic [11:0] v;
        sel_in = s;
        #1;
        case (which)
            0: v = sel_last_out;
            1: v = sel_avg_out;
            2: v = sel_min_out;
            default: v = sel_max_out;
        endcase
        check(name, 32'(v), 32'(exp));
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("den", 32'(den_out), 32'(exp_den));
            if (exp_den) check("daddr", 32'(daddr_out), 32'(exp_addr));
            check("dwe", 32'(dwe_out), 32'd0);
            check("di", 32'(di_out), 32'd0);
            check("upd_valid", 32'(upd_valid_out), 32'(exp_upd));
            if (exp_upd) begin
                check("upd_idx", 32'(upd_idx_out), 32'(exp_idx));
                check("upd_data", 32'(upd_data_out), 32'(exp_data));
            end
            check("sel_last", 32'(sel_last_out), 32'(m_last[sel_in]));
            check("sel_avg", 32'(sel_avg_out), 32'(m_avg[sel_in]));
            check("sel_min", 32'(sel_min_out), 32'(m_min[sel_in]));
            check("sel_max", 32'(sel_max_out), 32'(m_max[sel_in]));
            check("alarm", 32'(alarm_out), 32'(m_alarm));
            check("overrun_cnt", 32'(overrun_cnt_out), 32'(m_ovr));
            check("timeout_cnt", 32'(timeout_cnt_out), 32'(m_tmo));
        end
    end

    initial begin
        rst = 1'b1; eoc_in = 1'b0; channel_in = '0; drdy_in = 1'b0; do_in = '0;
        clr_minmax_in = 1'b0; sel_in = '0;
        thr_hi_in = {12'hFFF, 12'hFFF, 12'd1000, 12'hFFF};
        model_reset();
        tick(); tick();
        rst = 1'b0;
        chk_en = 1'b1;
        tick();
        lit("reset_min", 2'd2, 2, 12'hFFF);
        lit("reset_max", 2'd2, 3, 0);

        // Channel 0 read, drdy after 3 WAIT cycles
        do_read(5'h00, 3, 16'h9A30, 1'b0);
        lit("ch0_last", 2'd0, 0, 12'h9A3);
        check("model_ch0_last", 32'(m_last[0]), 32'h9A3);

        // Channel 6 block average
        do_read(5'h06, 1, 16'(100 << 4), 1'b0);
        do_read(5'h06, 0, 16'(200 << 4), 1'b0);
        do_read(5'h06, 2, 16'(300 << 4), 1'b0);
        lit("ch6_avg_pending", 2'd3, 1, 0);
        do_read(5'h06, 1, 16'(400 << 4), 1'b0);
        lit("ch6_avg", 2'd3, 1, 250);
        lit("ch6_min", 2'd3, 2, 100);
        lit("ch6_max", 2'd3, 3, 400);
        check("model_ch6_avg", 32'(m_avg[3]), 32'd250);

        // Channel 1 hysteresis alarm
        repeat (4) do_read(5'h01, 0, 16'(1001 << 4), 1'b0);
        check("alarm_set", 32'(alarm_out[1]), 32'd1);
        check("model_alarm_set", 32'(m_alarm[1]), 32'd1);
        repeat (4) do_read(5'h01, 1, 16'(990 << 4), 1'b0);
        check("alarm_hold", 32'(alarm_out[1]), 32'd1);
        repeat (4) do_read(5'h01, 0, 16'(984 << 4), 1'b0);
        check("alarm_clear", 32'(alarm_out[1]), 32'd0);
        check("model_alarm_clear", 32'(m_alarm[1]), 32'd0);

        // Channel 2 timeout with an overrun and an ignored unmatched eoc
        eoc_in = 1'b1; channel_in = 5'h02;
        tick();
        eoc_in = 1'b0; exp_den = 1'b1; exp_addr = 2;
        tick();
        exp_den = 1'b0;
        tick();
        eoc_in = 1'b1; channel_in = 5'h10;
        tick();
        channel_in = 5'h00;
        tick();
        eoc_in = 1'b0; m_ovr = 1;
        repeat (12) tick();
        check("no_timeout_yet", 32'(timeout_cnt_out), 32'd0);
        tick();
        m_tmo = 1;
        check("timeout_cnt", 32'(timeout_cnt_out), 32'd1);
        check("overrun_cnt", 32'(overrun_cnt_out), 32'd1);
        do_read(5'h02, 0, 16'h1230, 1'b0);

        // Unmatched channel
        eoc_in = 1'b1; channel_in = 5'h10;
        tick();
        eoc_in = 1'b0;
        repeat (3) tick();
        check("unmatched_ovr", 32'(overrun_cnt_out), 32'd1);
        check("unmatched_tmo", 32'(timeout_cnt_out), 32'd1);

        // Clear coinciding with a store on channel 0
        do_read(5'h00, 0, 16'h1000, 1'b1);
        lit("clr_store_min", 2'd0, 2, 12'h100);
        lit("clr_store_max", 2'd0, 3, 12'h100);
        lit("clr_other_min", 2'd3, 2, 12'hFFF);
        lit("clr_other_max", 2'd3, 3, 0);

        // Reset during WAIT, then a late drdy
        eoc_in = 1'b1; channel_in = 5'h06;
        tick();
        eoc_in = 1'b0; exp_den = 1'b1; exp_addr = 6;
        tick();
        exp_den = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        model_reset();
        rst = 1'b0;
        drdy_in = 1'b1; do_in = 16'h5550;
        tick();
        drdy_in = 1'b0; do_in = '0;
        repeat (2) tick();
        lit("rst_min", 2'd3, 2, 12'hFFF);
        lit("rst_last", 2'd3, 0, 0);
        check("rst_alarm", 32'(alarm_out), 32'd0);
        check("rst_tmo", 32'(timeout_cnt_out), 32'd0);

        // Normal operation after reset
        do_read(5'h06, 2, 16'h0FF0, 1'b0);
        lit("post_rst_last", 2'd3, 0, 12'h0FF);
        tick();
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/xadc_channel_monitor.md
Name: xadc_channel_monitor

Overview:
Parametrised successor to the fixed four-channel XADC latch. It sits between the XADC wizard (channel-sequencer mode) and user logic. On each end-of-conversion it runs a guarded DRP read and matches the result against a configurable channel table. Per channel it keeps last, block-averaged, min and max 12-bit codes, plus a hysteresis high-alarm. It also counts dropped conversions and DRP timeouts.

Parameters:
N_CH, 4, number of monitored channels (1..16)
CH_ADDRS, {7'h06,7'h02,7'h01,7'h00}, packed N_CH x 7-bit DRP addresses; entry i occupies bits [7i+6:7i]
AVG_LOG2, 2, block average over 2^AVG_LOG2 samples (0..6; 0 means avg = last)
HYST, 12'd16, alarm clear hysteresis in codes
TIMEOUT, 15, max cycles waiting for drdy after den

Ports:
clk  in  1  DRP clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
eoc_in  in  1  XADC end-of-conversion pulse
channel_in  in  5  XADC channel_out
den_out  out  1  DRP enable, one-cycle pulse
dwe_out  out  1  constant 0
di_out  out  16  constant 0
daddr_out  out  7  DRP address, held from den until drdy or timeout
drdy_in  in  1  DRP ready
do_in  in  16  DRP data; code = do_in[15:4]
thr_hi_in  in  12*N_CH  per-channel alarm thresholds
clr_minmax_in  in  1  pulse: reset all min/max trackers
sel_in  in  SEL_W  channel index for readback; SEL_W = max(1, clog2(N_CH))
sel_last_out  out  12  last code of selected channel (combinational mux of registers)
sel_avg_out  out  12  block average of selected channel
sel_min_out  out  12  minimum of selected channel
sel_max_out  out  12  maximum of selected channel
upd_valid_out  out  1  one-cycle pulse: a channel was updated
upd_idx_out  out  SEL_W  index of updated channel
upd_data_out  out  12  code just stored
alarm_out  out  N_CH  per-channel high alarm
overrun_cnt_out  out  8  saturating count of dropped eoc
timeout_cnt_out  out  8  saturating count of DRP timeouts

Behaviour:
- Reset values: all last/avg/max = 0; min = 12'hFFF; accumulators and sample counters = 0; alarm = 0; counters = 0; den/upd_valid = 0; daddr = 0; FSM = IDLE.
- Match: {2'b0, channel_in} is compared to each CH_ADDRS entry and the lowest matching index wins. If there is no match, eoc_in is ignored: no read, no count.
- FSM states and transitions:
  - IDLE: on matching eoc_in, latch index and address, go to REQ.
  - REQ: den_out = 1 for exactly this cycle with daddr valid; go to WAIT with the timer cleared.
  - WAIT: if drdy_in, capture do_in[15:4] and go to STORE. Otherwise the timer increments; when the timer reaches TIMEOUT, timeout_cnt increments (saturating at 255) and the FSM returns to IDLE with no update.
  - STORE: write last, then update min/max (after clear), accumulator, avg and alarm; upd_valid = 1 for one cycle carrying idx/data; return to IDLE.
- Latency: eoc to den is 1 cycle. drdy to upd_valid is 1 cycle.
- Matching eoc_in arriving in REQ/WAIT/STORE is dropped: overrun_cnt increments (saturating at 255) and no queueing occurs. Unmatched eoc_in never counts as an overrun.
- Averaging:
  - acc[i] width is 12+AVG_LOG2. Each sample adds to acc[i] and increments cnt[i].
  - When cnt[i] wraps from 2^AVG_LOG2-1 to 0, avg[i] = (acc[i] + sample) >> AVG_LOG2, truncated, and acc[i] restarts at 0.
  - With AVG_LOG2 = 0, avg updates every sample.
- Alarm, evaluated only when avg[i] updates:
  - Set when new avg > thr_hi[i].
  - Clear when new avg + HYST <= thr_hi[i]; compute at 13 bits, no underflow.
  - Otherwise hold.
- clr_minmax_in: min = FFF and max = 0 for all channels. If it coincides with STORE, the clear applies first and the stored sample then updates min/max of its own channel.
- rst mid-read: immediate return to IDLE with all reset values. A late drdy_in arriving in IDLE is ignored.
- sel_in >= N_CH: all sel_* outputs read 0.

Test Plan:
- Defaults, eoc with channel 0, drdy after 3 cycles with do_in = 16'h9A30 -> den 1 cycle after eoc with daddr 0; upd_valid 1 cycle after drdy, idx 0, data 12'h9A3; sel_last = 9A3.
- Channel 6 samples 100, 200, 300, 400 (AVG_LOG2 = 2) -> avg stays 0 until the 4th sample, then 250; min 100, max 400.
- thr_hi[1] = 1000, HYST = 16; averages 1001, 990, 984 -> alarm[1] 1, then 1 (held), then 0.
- eoc on channel 2, no drdy -> 16 cycles in WAIT, timeout_cnt = 1, no upd_valid; a second eoc during WAIT -> overrun_cnt = 1.
- eoc with channel 5'h10 (unmatched) -> no den, counters unchanged.
- rst asserted in WAIT, then drdy arrives -> no update; all outputs at reset values; min reads FFF.
